// File: rtl/axi_mem_responder.sv
// AXI-style memory slave: one write burst and one read burst in flight at a time.
// Read and write channels run independently. INCR bursts wrap within the storage.
module axi_mem_responder #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 6,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  localparam int NB = DATA_W / 8;
  typedef logic [MEM_AW-1:0] idx_t;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  // Only the word-index bits of the addresses matter; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:MEM_AW+3], awaddr[2:0],
                              araddr[31:MEM_AW+3], araddr[2:0]};

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_next;

  logic [ID_W-1:0] w_id;
  idx_t            w_idx;
  logic [3:0]      w_len, w_beat;
  logic            w_err;
  logic            w_fire;

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin awready = 1'b1; if (awvalid) w_next = W_DATA; end
      W_DATA: begin wready = 1'b1; if (wvalid && w_beat == w_len) w_next = W_RESP; end
      W_RESP: begin bvalid = 1'b1; if (bready) w_next = W_IDLE; end
      default: w_next = W_IDLE;
    endcase
  end

  assign w_fire = wvalid && wready && !reset;
  assign bid    = w_id;
  assign bresp  = {bvalid & w_err, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      w_id <= '0; w_idx <= '0; w_len <= '0; w_beat <= '0; w_err <= 1'b0;
    end else if (awvalid && awready) begin
      w_id   <= awid;
      w_idx  <= awaddr[MEM_AW+2:3];
      w_len  <= awlen;
      w_beat <= '0;
      w_err  <= 1'b0;
    end else if (w_fire) begin
      w_idx  <= w_idx + idx_t'(1);
      w_beat <= w_beat + 4'd1;
      // The beat count, not wlast, ends the burst; a misplaced wlast is only reported.
      if (wlast != (w_beat == w_len)) w_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire)
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t r_state, r_next;

  idx_t       r_idx;
  logic [3:0] r_len, r_beat;

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin arready = 1'b1; if (arvalid) r_next = R_DATA; end
      R_DATA: begin rvalid = 1'b1; if (rready && r_beat == r_len) r_next = R_IDLE; end
      default: r_next = R_IDLE;
    endcase
  end

  assign rlast = rvalid && (r_beat == r_len);
  assign rresp = 2'b00;

  // rdata is a register prefetched one beat ahead, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      rid <= '0; rdata <= '0; r_idx <= '0; r_len <= '0; r_beat <= '0;
    end else if (arvalid && arready) begin
      rid    <= arid;
      r_len  <= arlen;
      r_beat <= '0;
      rdata  <= mem[araddr[MEM_AW+2:3]];
      r_idx  <= araddr[MEM_AW+2:3] + idx_t'(1);
    end else if (rvalid && rready && !rlast) begin
      rdata  <= mem[r_idx];
      r_idx  <= r_idx + idx_t'(1);
      r_beat <= r_beat + 4'd1;
    end
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning bus data width in bits (8-byte words).
REQ-002 SHALL have parameter ID_W, default 6, meaning transaction ID width.
REQ-003 SHALL have parameter MEM_AW, default 10, meaning log2 of the number of DATA_W words of storage.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 awid  input  ID_W  write ID.
REQ-007 awaddr  input  32  write byte address.
REQ-008 awlen  input  4  write beats minus one (1..16 beats).
REQ-009 awvalid  input  1  write address valid.
REQ-010 awready  output  1  write address accepted.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 wstrb  input  DATA_W/8  byte enables.
REQ-013 wlast  input  1  final write beat marker.
REQ-014 wvalid  input  1  write data valid.
REQ-015 wready  output  1  write data accepted.
REQ-016 bid  output  ID_W  write response ID.
REQ-017 bresp  output  2  write response: 00 OKAY, 10 SLVERR.
REQ-018 bvalid  output  1  write response valid.
REQ-019 bready  input  1  write response accepted.
REQ-020 arid  input  ID_W  read ID.
REQ-021 araddr  input  32  read byte address.
REQ-022 arlen  input  4  read beats minus one.
REQ-023 arvalid  input  1  read address valid.
REQ-024 arready  output  1  read address accepted.
REQ-025 rid  output  ID_W  read data ID.
REQ-026 rdata  output  DATA_W  read data.
REQ-027 rresp  output  2  read response, constant 00.
REQ-028 rlast  output  1  final read beat.
REQ-029 rvalid  output  1  read data valid.
REQ-030 rready  input  1  read data accepted.

Function
REQ-031 Storage SHALL be 2^MEM_AW words; word index = addr[MEM_AW+2:3]; upper address bits ignored (aliasing); low 3 bits ignored; bursts INCR only, index wraps modulo 2^MEM_AW.
REQ-032 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); all other cycles these are 0.
REQ-033 W_IDLE: awvalid&awready latches awid, index, awlen, clears beat count and error flag -> W_DATA next cycle.
REQ-034 W_DATA: each wvalid&wready writes bytes i of word[index] where wstrb[i]=1, then index+1, beat+1; W beats before AW acceptance are not accepted.
REQ-035 Beat count reaching awlen (the last beat) SHALL move to W_RESP regardless of wlast; wlast on any other beat, or wlast=0 on the last, sets the error flag.
REQ-036 W_RESP: bid = latched awid, bresp = 10 if error flag else 00; bvalid held until bready -> W_IDLE; bvalid rises the cycle after the last W handshake.
REQ-037 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1).
REQ-038 R_IDLE: arvalid&arready latches arid, arlen, loads rdata <= word[index], beat=0 -> R_DATA; first rvalid one cycle after AR handshake.
REQ-039 R_DATA: rlast=1 when beat==arlen; rvalid&rready non-last loads next word, beat+1 (back-to-back beats when rready held 1); last handshake -> R_IDLE; rid/rdata/rlast stable while rready=0.
REQ-040 Read and write channels SHALL operate concurrently and independently.
REQ-041 Read load in the same cycle as a write to that word SHALL return the pre-write value.

Reset
REQ-042 On reset: both FSMs idle; awready=1, arready=1, wready=0, bvalid=0, bresp=00, bid=0, rvalid=0, rlast=0, rid=0, rdata=0; storage not cleared; reset mid-burst abandons it with no B/R output.

Verification
REQ-043 AW addr 0x40 len 3 id 5, W 0x11,0x22,0x33,0x44 wstrb 0xFF wlast on 4th, bready=1 -> bvalid one cycle after 4th beat, bid=5, bresp=00.
REQ-044 AR addr 0x40 len 3 id 9, rready=1 -> rvalid cycle after AR, 0x11..0x44 on consecutive cycles, rid=9, rlast only with 0x44.
REQ-045 Word 0x80 = all-ones, write 0x0 wstrb 0x0F len 0 -> readback 0xFFFFFFFF_00000000.
REQ-046 Read len 3 with rready toggling 1,0,0,1... -> each beat delivered once, rdata stable during stall, 4 handshakes total.
REQ-047 Write len 3 with wlast on beat 2 -> four beats accepted, bresp=10.
REQ-048 Reset asserted mid-write after 2 beats -> next cycle awready=1, wready=0, bvalid=0; new AW accepted normally.
